// File: rtl/uart_tx.sv
// uart_tx: FIFO-draining UART transmitter, 8N1/8E1/8O1 framing with 1 or 2 stop bits
module uart_tx #(
  parameter int DataWidth  = 8,
  parameter int ClksPerBit = 868,
  parameter int ParityEn   = 0,
  parameter int ParityOdd  = 0,
  parameter int StopBits   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_fifo_empty,
  input  logic [DataWidth-1:0] i_fifo_rd_data,
  output logic                 o_fifo_rd_en,
  output logic                 o_tx,
  output logic                 o_busy
);
  localparam int cw = $clog2(ClksPerBit);
  localparam int bw = $clog2(DataWidth + StopBits + 1);
  localparam logic [cw-1:0] baud_last = cw'(ClksPerBit - 1);
  localparam logic [bw-1:0] data_last = bw'(DataWidth - 1);
  localparam logic [bw-1:0] stop_last = bw'(StopBits - 1);
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t               state, state_d;
  logic [cw-1:0]        baud, baud_d;
  logic [bw-1:0]        bit_cnt, bit_d;
  logic [DataWidth-1:0] shreg, shreg_d;
  logic                 par, par_d, tx_d, rd_en_d, busy_d, bit_end, serial;
  assign bit_end = baud == baud_last;
  // the baud counter only runs while a bit is on the line
  assign serial = state inside {START, DATA, PARITY, STOP};
  always_comb begin
    state_d = state;
    baud_d  = serial ? (bit_end ? '0 : baud + 1'b1) : '0;
    bit_d   = bit_cnt;
    shreg_d = shreg;
    par_d   = par;
    tx_d    = o_tx;
    rd_en_d = 1'b0;
    busy_d  = o_busy;
    case (state)
      IDLE: begin
        state_d = i_fifo_empty ? IDLE : REQ;
        rd_en_d = !i_fifo_empty;
        busy_d  = !i_fifo_empty;
      end
      REQ: state_d = LOAD;
      LOAD: begin
        shreg_d = i_fifo_rd_data;
        par_d   = ^i_fifo_rd_data ^ 1'(ParityOdd);
        tx_d    = 1'b0;
        bit_d   = '0;
        state_d = START;
      end
      START: if (bit_end) begin
        state_d = DATA;
        tx_d    = shreg[0];
        shreg_d = shreg >> 1;
      end
      DATA: if (bit_end) begin
        if (bit_cnt == data_last) begin
          bit_d   = '0;
          state_d = (ParityEn != 0) ? PARITY : STOP;
          tx_d    = (ParityEn != 0) ? par : 1'b1;
        end else begin
          bit_d   = bit_cnt + 1'b1;
          tx_d    = shreg[0];
          shreg_d = shreg >> 1;
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (bit_end) begin
        // the final stop edge doubles as the next pop decision
        if (bit_cnt != stop_last) begin
          bit_d = bit_cnt + 1'b1;
        end else begin
          bit_d   = '0;
          state_d = i_fifo_empty ? IDLE : REQ;
          rd_en_d = !i_fifo_empty;
          busy_d  = !i_fifo_empty;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      baud         <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par          <= 1'b0;
      o_tx         <= 1'b1;
      o_fifo_rd_en <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_d;
      baud         <= baud_d;
      bit_cnt      <= bit_d;
      shreg        <= shreg_d;
      par          <= par_d;
      o_tx         <= tx_d;
      o_fifo_rd_en <= rd_en_d;
      o_busy       <= busy_d;
    end
  end
endmodule
